opsum_ppu: RTL and testbench

Post-processing unit that sits directly downstream of the PE array's opsum port. It consumes the 32-bit signed partial-sum stream over a valid/ready handshake and requantizes each value: rounding arithmetic right shift, optional ReLU, saturation to int8, then offset-binary conversion back to uint8 (XOR 0x80, the inverse of the PE's ifmap conversion). It packs four results per 32-bit word for write-back to the global buffer as the next layer's ifmap.

---
 rtl/opsum_ppu_pkg.sv | 14 +
 rtl/ppu_quant.sv | 46 ++++
 rtl/opsum_ppu.sv | 145 ++++++++++++++
 tb/tb_opsum_ppu.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_ppu_pkg.sv
// Shared definitions for the opsum post-processing unit: FSM encoding and packing geometry.
package opsum_ppu_pkg;

  localparam int PPU_PACK     = 4;
  localparam int PPU_OUT_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ppu_state_e;

endpackage

// File: rtl/ppu_quant.sv
// Combinational requantizer: rounding arithmetic shift, optional ReLU, int8 saturation,
// then offset-binary conversion to uint8.
module ppu_quant
  import opsum_ppu_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int OUT_BITS  = PPU_OUT_BITS
) (
  input  logic signed [DATA_BITS-1:0] x,
  input  logic        [4:0]           shift,
  input  logic                        relu,
  output logic        [OUT_BITS-1:0]  qbyte
);

  localparam logic signed [DATA_BITS:0] MAX_V = (DATA_BITS+1)'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [DATA_BITS:0] MIN_V = ~MAX_V;

  logic signed [DATA_BITS:0] x_ext;
  logic signed [DATA_BITS:0] rnd;
  logic signed [DATA_BITS:0] sum;
  logic signed [DATA_BITS:0] r;
  logic        [OUT_BITS-1:0] sat;

  // One guard bit keeps x + 2^(s-1) from overflowing for any 32-bit x.
  always_comb begin
    x_ext = {x[DATA_BITS-1], x};
    rnd   = '0;
    if (shift != 5'd0) begin
      rnd = (DATA_BITS+1)'(1) << (shift - 5'd1);
    end
    sum = x_ext + rnd;
    r   = sum >>> shift;
    if (relu && (r < 0)) begin
      r = '0;
    end
    if (r > MAX_V) begin
      sat = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (r < MIN_V) begin
      sat = {1'b1, {(OUT_BITS-1){1'b0}}};
    end else begin
      sat = r[OUT_BITS-1:0];
    end
    qbyte = sat ^ {1'b1, {(OUT_BITS-1){1'b0}}};
  end

endmodule

// File: rtl/opsum_ppu.sv
// Post-processing unit: requantizes the PE opsum stream and packs PACK uint8 results
// per output word for write-back as the next layer's ifmap.
module opsum_ppu
  import opsum_ppu_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int OUT_BITS  = PPU_OUT_BITS,
  parameter int PACK      = PPU_PACK,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ppu_en,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [CNT_BITS-1:0]  cfg_count,
  input  logic [DATA_BITS-1:0] ipsum,
  input  logic                 ipsum_valid,
  output logic                 ipsum_ready,
  output logic [DATA_BITS-1:0] opack,
  output logic                 opack_valid,
  input  logic                 opack_ready,
  output logic                 done
);

  localparam int LANE_BITS = (PACK > 1) ? $clog2(PACK) : 1;

  ppu_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]   remaining_q, remaining_d;
  logic [LANE_BITS-1:0]  lane_cnt_q, lane_cnt_d;
  logic [4:0]            shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic [DATA_BITS-1:0]  pack_q, pack_d;
  logic [DATA_BITS-1:0]  out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  logic [OUT_BITS-1:0]   q_byte;
  logic [DATA_BITS-1:0]  merged;
  logic                  completes_word;
  logic                  accept;
  logic                  out_hs;

  ppu_quant #(
    .DATA_BITS (DATA_BITS),
    .OUT_BITS  (OUT_BITS)
  ) u_quant (
    .x     (ipsum),
    .shift (shift_q),
    .relu  (relu_q),
    .qbyte (q_byte)
  );

  // Current word with the incoming byte dropped into its lane.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign merged[gi*OUT_BITS +: OUT_BITS] =
      (lane_cnt_q == LANE_BITS'(gi)) ? q_byte : pack_q[gi*OUT_BITS +: OUT_BITS];
  end

  assign completes_word = (lane_cnt_q == LANE_BITS'(PACK-1)) || (remaining_q == CNT_BITS'(1));
  assign ipsum_ready    = (state_q == ST_RUN) && (!completes_word || !out_valid_q || opack_ready);
  assign accept         = ipsum_valid && ipsum_ready;
  assign out_hs         = out_valid_q && opack_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_cnt_d  = lane_cnt_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    pack_d      = pack_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (ppu_en) begin
          state_d     = ST_RUN;
          shift_d     = cfg_shift;
          relu_d      = cfg_relu;
          remaining_d = (cfg_count == '0) ? CNT_BITS'(1) : cfg_count;
          lane_cnt_d  = '0;
          pack_d      = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_BITS'(1);
          if (completes_word) begin
            // A word completing on the same edge as a handshake simply replaces out_q.
            out_d       = merged;
            out_valid_d = 1'b1;
            lane_cnt_d  = '0;
            pack_d      = '0;
            if (remaining_q == CNT_BITS'(1)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            pack_d     = merged;
            lane_cnt_d = lane_cnt_q + LANE_BITS'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lane_cnt_q  <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      pack_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_cnt_q  <= lane_cnt_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      pack_q      <= pack_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign opack       = out_q;
  assign opack_valid = out_valid_q;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_opsum_ppu.sv
// Directed bench for opsum_ppu: packing, saturation, rounding, ReLU, backpressure, reset.
module tb_opsum_ppu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ppu_en;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [15:0] cfg_count;
  logic [31:0] ipsum;
  logic        ipsum_valid;
  logic        ipsum_ready;
  logic [31:0] opack;
  logic        opack_valid;
  logic        opack_ready;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int job_done0 = 0;
  logic [31:0] got_q[$];
  logic [31:0] stim_q[$];

  opsum_ppu dut (
    .clk         (clk),
    .rst         (rst),
    .ppu_en      (ppu_en),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .cfg_count   (cfg_count),
    .ipsum       (ipsum),
    .ipsum_valid (ipsum_valid),
    .ipsum_ready (ipsum_ready),
    .opack       (opack),
    .opack_valid (opack_valid),
    .opack_ready (opack_ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so a negedge sample shows what the next edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      if (opack_valid && opack_ready) begin
        got_q.push_back(opack);
        $display("opack handshake: %h", opack);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_q(input logic [31:0] x, input int s, input bit relu);
    longint r;
    r = longint'($signed(x));
    if (s > 0) r = (r + (longint'(1) << (s - 1))) >>> s;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r) ^ 8'h80;
  endfunction

  task automatic start_job(input logic [4:0] s, input bit relu, input logic [15:0] cnt);
    @(posedge clk); #1;
    ppu_en = 1'b1; cfg_shift = s; cfg_relu = relu; cfg_count = cnt;
    job_done0 = done_cnt;
    got_q.delete();
    @(posedge clk); #1;
    ppu_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] v, output bit acc);
    ipsum = v; ipsum_valid = 1'b1; acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = ipsum_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_job(output bit to, output int ndone);
    ipsum_valid = 1'b0; to = 1'b0;
    for (int c = 0; c < 100 && done_cnt == job_done0; c++) @(posedge clk);
    if (done_cnt == job_done0) to = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ndone = done_cnt - job_done0;
  endtask

  task automatic run_job(input logic [4:0] s, input bit relu, input logic [15:0] cnt,
                         output bit to, output int ndone);
    bit acc;
    bit miss;
    miss = 1'b0;
    start_job(s, relu, cnt);
    foreach (stim_q[i]) begin
      push(stim_q[i], acc);
      if (!acc) miss = 1'b1;
    end
    finish_job(to, ndone);
    to = to | miss;
  endtask

  task automatic test_reset();
    rst = 1'b1; ppu_en = 1'b0; cfg_shift = '0; cfg_relu = 1'b0; cfg_count = '0;
    ipsum = '0; ipsum_valid = 1'b0; opack_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (opack !== 32'h0) begin n_fail++; $display("FAIL reset_opack: got %h want 00000000", opack); end
    n_checks++; if (opack_valid !== 1'b0) begin n_fail++; $display("FAIL reset_opack_valid: got %b want 0", opack_valid); end
    n_checks++; if (ipsum_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ipsum_ready: got %b want 0", ipsum_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ipsum_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ipsum_ready: got %b want 0", ipsum_ready); end
  endtask

  task automatic test_basic_pack();
    bit to; int nd;
    logic [31:0] exp_w[$];
    stim_q = '{32'd1, 32'hFFFFFFFF, 32'd127, 32'hFFFFFF80};
    exp_w  = '{32'h00FF7F81};
    run_job(5'd0, 1'b0, 16'd4, to, nd);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", nd); end
    n_checks++; if (got_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL basic_words: got %0d want %0d", got_q.size(), exp_w.size()); end
    foreach (exp_w[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_w[i]);
      end
    end
  endtask

  task automatic test_saturation();
    bit to; int nd;
    logic [31:0] exp_w[$];
    stim_q = '{32'h0000012C, 32'hFFFFFED4, 32'h00000080, 32'hFFFFFF7F};
    exp_w  = '{32'h00FF00FF};
    run_job(5'd0, 1'b0, 16'd4, to, nd);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL sat_timeout: got %b want 0", to); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL sat_done_pulses: got %0d want 1", nd); end
    n_checks++; if (got_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL sat_words: got %0d want %0d", got_q.size(), exp_w.size()); end
    foreach (exp_w[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL sat_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_w[i]);
      end
    end
  endtask

  task automatic test_rounding();
    bit to; int nd;
    logic [31:0] exp_w[$];
    stim_q = '{32'd6, 32'hFFFFFFFA, 32'd5, 32'hFFFFFFF9};
    exp_w  = '{32'h7E817F82};
    run_job(5'd2, 1'b0, 16'd4, to, nd);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL round_timeout: got %b want 0", to); end
    n_checks++; if (got_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL round_words: got %0d want %0d", got_q.size(), exp_w.size()); end
    foreach (exp_w[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL round_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_w[i]);
      end
    end
  endtask

  task automatic test_relu_partial();
    bit to; int nd;
    logic [31:0] exp_w[$];
    stim_q = '{32'hFFFFFFFB, 32'd1, 32'd2, 32'd3, 32'd4};
    exp_w  = '{32'h83828180, 32'h00000084};
    run_job(5'd0, 1'b1, 16'd5, to, nd);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL relu_timeout: got %b want 0", to); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL relu_done_pulses: got %0d want 1", nd); end
    n_checks++; if (got_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL relu_words: got %0d want %0d", got_q.size(), exp_w.size()); end
    foreach (exp_w[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL relu_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_w[i]);
      end
    end
  endtask

  // count=0 behaves as a single-element job; shift=31 exercises the widest rounding add.
  task automatic test_count_zero_shift31();
    bit to; int nd;
    stim_q = '{32'h7FFFFFFF};
    run_job(5'd31, 1'b0, 16'd0, to, nd);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL cnt0_timeout: got %b want 0", to); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL cnt0_done_pulses: got %0d want 1", nd); end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL cnt0_words: got %0d want 1", got_q.size()); end
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 32'h00000081) begin
      n_fail++; $display("FAIL cnt0_word: got %h want 00000081", (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v[64];
    logic [31:0] exp_w[16];
    logic [31:0] prev_w;
    bit prev_hold, acc, exp_rdy, to;
    int k, nd;
    for (int i = 0; i < 64; i++) begin
      v[i] = (i % 2 == 1) ? (32'($urandom_range(0, 2000)) - 32'd1000) : 32'($urandom);
    end
    for (int w = 0; w < 16; w++) begin
      exp_w[w] = {model_q(v[4*w+3], 3, 1'b0), model_q(v[4*w+2], 3, 1'b0),
                  model_q(v[4*w+1], 3, 1'b0), model_q(v[4*w], 3, 1'b0)};
    end
    start_job(5'd3, 1'b0, 16'd64);
    k = 0; prev_hold = 1'b0; prev_w = '0;
    fork
      begin
        ipsum = v[0]; ipsum_valid = 1'b1;
        for (int c = 0; c < 2000 && k < 64; c++) begin
          @(negedge clk);
          exp_rdy = !((k % 4 == 3) && opack_valid && !opack_ready);
          n_checks++;
          if (ipsum_ready !== exp_rdy) begin
            n_fail++; $display("FAIL bp_ready_elem%0d: got %b want %b", k, ipsum_ready, exp_rdy);
          end
          if (prev_hold) begin
            n_checks++;
            if (opack_valid !== 1'b1 || opack !== prev_w) begin
              n_fail++; $display("FAIL bp_hold: got valid=%b %h want valid=1 %h", opack_valid, opack, prev_w);
            end
          end
          prev_hold = opack_valid && !opack_ready;
          prev_w = opack;
          acc = ipsum_ready;
          @(posedge clk); #1;
          if (acc) begin
            k++;
            if (k < 64) ipsum = v[k];
          end
        end
        ipsum_valid = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1 opack_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 opack_ready = 1'b1;
      end
    join
    finish_job(to, nd);
    n_checks++; if (k !== 64) begin n_fail++; $display("FAIL bp_accepted: got %0d want 64", k); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b want 0", to); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", nd); end
    n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL bp_words: got %0d want 16", got_q.size()); end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (w >= got_q.size() || got_q[w] !== exp_w[w]) begin
        n_fail++; $display("FAIL bp_word%0d: got %h want %h", w, (w < got_q.size()) ? got_q[w] : 32'hx, exp_w[w]);
      end
    end
  endtask

  task automatic test_reset_reenable();
    bit acc, to; int nd, d0;
    logic [31:0] exp_w[$];
    start_job(5'd0, 1'b0, 16'd4);
    push(32'd1, acc);
    push(32'd2, acc);
    #2 rst = 1'b1;
    #1;
    d0 = done_cnt;
    n_checks++; if (opack !== 32'h0) begin n_fail++; $display("FAIL midrst_opack: got %h want 00000000", opack); end
    n_checks++; if (opack_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_opack_valid: got %b want 0", opack_valid); end
    n_checks++; if (ipsum_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ipsum_ready: got %b want 0", ipsum_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Still offering psums: IDLE must ignore them.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (ipsum_ready !== 1'b0 || opack_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_ignore_cyc%0d: got ready=%b valid=%b want 0 0", c, ipsum_ready, opack_valid);
      end
    end
    @(posedge clk); #1;
    ipsum_valid = 1'b0;
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end

    stim_q = '{32'd3, 32'hFFFFFFFD, 32'd255, 32'hFFFFFC18};
    exp_w  = '{32'h00FF7F82};
    run_job(5'd1, 1'b0, 16'd4, to, nd);
    n_checks++; if (to !== 1'b0 || nd !== 1) begin n_fail++; $display("FAIL reen_job: got timeout=%b done=%0d want 0 1", to, nd); end
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_w[0]) begin
      n_fail++; $display("FAIL reen_word: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, exp_w[0]);
    end

    // ppu_en with a different config in the middle of RUN must not restart the job.
    start_job(5'd0, 1'b0, 16'd4);
    push(32'd10, acc);
    push(32'd20, acc);
    ppu_en = 1'b1; cfg_shift = 5'd4; cfg_relu = 1'b1; cfg_count = 16'd1;
    push(32'd30, acc);
    ppu_en = 1'b0;
    push(32'd40, acc);
    finish_job(to, nd);
    n_checks++; if (to !== 1'b0 || nd !== 1) begin n_fail++; $display("FAIL en_in_run_job: got timeout=%b done=%0d want 0 1", to, nd); end
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== 32'hA89E948A) begin
      n_fail++; $display("FAIL en_in_run_word: got %0d words first %h want 1 word a89e948a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_saturation();
    test_rounding();
    test_relu_partial();
    test_count_zero_shift31();
    test_backpressure();
    test_reset_reenable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
